// File: rtl/register_status_table.sv
// Register status table: maps each architectural register to the ROB tag of its pending producer.
// Tag 0 means the architectural register file holds the current value.
module register_status_table #(
    parameter int unsigned NREGS   = 32,
    parameter int unsigned ROBEN_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         Decoded_Rs,
    input  logic [4:0]         Decoded_Rt,
    input  logic [4:0]         Decoded_Rd,
    input  logic               Decoded_WriteEn,
    input  logic [ROBEN_W-1:0] Decoded_ROBEN,
    input  logic               VALID_Inst,
    input  logic               FULL_FLAG,
    input  logic               Commit_Valid,
    input  logic [4:0]         Commit_Rd,
    input  logic [ROBEN_W-1:0] Commit_ROBEN,
    input  logic               FLUSH_Flag,
    output logic [ROBEN_W-1:0] RP_ROBEN1,
    output logic [ROBEN_W-1:0] RP_ROBEN2,
    output logic               RP_Busy1,
    output logic               RP_Busy2,
    output logic               Alloc_Done,
    output logic [5:0]         Busy_Count,
    input  logic [4:0]         index_test,
    output logic [ROBEN_W-1:0] Reg_ROBEN_test
);

    logic [ROBEN_W-1:0] tag_q [NREGS];
    logic [ROBEN_W-1:0] tag_d [NREGS];
    logic [5:0]         busy_count_q;
    logic [5:0]         busy_count_d;
    logic               alloc_done_q;
    logic               alloc_done_d;

    logic alloc;
    logic clr;

    always_comb begin
        alloc = VALID_Inst && !FULL_FLAG && Decoded_WriteEn
                && (Decoded_Rd != '0) && !FLUSH_Flag;
        clr   = Commit_Valid && (Commit_Rd != '0)
                && (tag_q[Commit_Rd] == Commit_ROBEN);
    end

    // Clear is applied before allocate so a same-register alloc wins.
    always_comb begin
        tag_d = tag_q;
        if (clr) begin
            tag_d[Commit_Rd] = '0;
        end
        if (alloc) begin
            tag_d[Decoded_Rd] = Decoded_ROBEN;
        end
        if (FLUSH_Flag) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                tag_d[i] = '0;
            end
        end
        alloc_done_d = alloc;
    end

    // Counting the next table directly keeps the busy count exact for every
    // alloc/commit/flush combination, including a commit of tag 0.
    always_comb begin
        busy_count_d = '0;
        for (int unsigned i = 1; i < NREGS; i++) begin
            busy_count_d = busy_count_d + 6'(tag_d[i] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tag_q        <= '{default: '0};
            busy_count_q <= '0;
            alloc_done_q <= 1'b0;
        end else begin
            tag_q        <= tag_d;
            busy_count_q <= busy_count_d;
            alloc_done_q <= alloc_done_d;
        end
    end

    always_comb begin
        RP_ROBEN1      = (Decoded_Rs == '0) ? '0 : tag_q[Decoded_Rs];
        RP_ROBEN2      = (Decoded_Rt == '0) ? '0 : tag_q[Decoded_Rt];
        RP_Busy1       = (RP_ROBEN1 != '0);
        RP_Busy2       = (RP_ROBEN2 != '0);
        Reg_ROBEN_test = (index_test == '0) ? '0 : tag_q[index_test];
        Alloc_Done     = alloc_done_q;
        Busy_Count     = busy_count_q;
    end

endmodule

// File: tb/tb_register_status_table.sv
// Bench for register_status_table: directed scenarios plus random traffic
// checked against an array-based model of the rename map.
module tb_register_status_table;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] Decoded_Rs, Decoded_Rt, Decoded_Rd;
    logic       Decoded_WriteEn;
    logic [4:0] Decoded_ROBEN;
    logic       VALID_Inst, FULL_FLAG;
    logic       Commit_Valid;
    logic [4:0] Commit_Rd, Commit_ROBEN;
    logic       FLUSH_Flag;
    logic [4:0] RP_ROBEN1, RP_ROBEN2;
    logic       RP_Busy1, RP_Busy2, Alloc_Done;
    logic [5:0] Busy_Count;
    logic [4:0] index_test;
    logic [4:0] Reg_ROBEN_test;

    int checks = 0;
    int errors = 0;
    int m_tag [32];
    int m_alloc_done = 0;

    register_status_table #(.NREGS(32), .ROBEN_W(5)) dut (
        .clk(clk), .rst(rst),
        .Decoded_Rs(Decoded_Rs), .Decoded_Rt(Decoded_Rt), .Decoded_Rd(Decoded_Rd),
        .Decoded_WriteEn(Decoded_WriteEn), .Decoded_ROBEN(Decoded_ROBEN),
        .VALID_Inst(VALID_Inst), .FULL_FLAG(FULL_FLAG),
        .Commit_Valid(Commit_Valid), .Commit_Rd(Commit_Rd), .Commit_ROBEN(Commit_ROBEN),
        .FLUSH_Flag(FLUSH_Flag),
        .RP_ROBEN1(RP_ROBEN1), .RP_ROBEN2(RP_ROBEN2),
        .RP_Busy1(RP_Busy1), .RP_Busy2(RP_Busy2),
        .Alloc_Done(Alloc_Done), .Busy_Count(Busy_Count),
        .index_test(index_test), .Reg_ROBEN_test(Reg_ROBEN_test)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic int m_busy();
        int n = 0;
        for (int i = 1; i < 32; i++) if (m_tag[i] != 0) n++;
        return n;
    endfunction

    function automatic int m_read(input int r);
        return (r == 0) ? 0 : m_tag[r];
    endfunction

    task automatic idle();
        rst = 1'b1;
        Decoded_Rs = '0; Decoded_Rt = '0; Decoded_Rd = '0;
        Decoded_WriteEn = 1'b0; Decoded_ROBEN = '0;
        VALID_Inst = 1'b0; FULL_FLAG = 1'b0;
        Commit_Valid = 1'b0; Commit_Rd = '0; Commit_ROBEN = '0;
        FLUSH_Flag = 1'b0;
    endtask

    // Checks reads against the model, advances one edge, applies the
    // rename-map rules to the model, then checks registered outputs.
    task automatic tick();
        int  nxt [32];
        bit  alloc, clr;
        #1;
        check("rd1", RP_ROBEN1, m_read(Decoded_Rs));
        check("rd2", RP_ROBEN2, m_read(Decoded_Rt));
        check("busy1", RP_Busy1, m_read(Decoded_Rs) != 0);
        check("busy2", RP_Busy2, m_read(Decoded_Rt) != 0);
        alloc = VALID_Inst && !FULL_FLAG && Decoded_WriteEn && Decoded_Rd != 0 && !FLUSH_Flag;
        clr   = Commit_Valid && Commit_Rd != 0 && m_tag[Commit_Rd] == int'(Commit_ROBEN);
        nxt = m_tag;
        if (!rst || FLUSH_Flag) begin
            foreach (nxt[i]) nxt[i] = 0;
            m_alloc_done = (!rst) ? 0 : int'(alloc);
        end else begin
            if (clr)   nxt[Commit_Rd]  = 0;
            if (alloc) nxt[Decoded_Rd] = Decoded_ROBEN;
            m_alloc_done = int'(alloc);
        end
        @(posedge clk);
        #1;
        m_tag = nxt;
        check("count", Busy_Count, m_busy());
        check("adone", Alloc_Done, m_alloc_done);
        check("dbg", Reg_ROBEN_test, m_read(index_test));
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic alloc_op(input int rd, input int tg);
        idle();
        VALID_Inst = 1'b1; Decoded_WriteEn = 1'b1;
        Decoded_Rd = 5'(rd); Decoded_ROBEN = 5'(tg);
        tick();
    endtask

    task automatic commit_op(input int rd, input int tg);
        idle();
        Commit_Valid = 1'b1; Commit_Rd = 5'(rd); Commit_ROBEN = 5'(tg);
        tick();
    endtask

    task automatic peek(input string tag, input int r, input int expected);
        index_test = 5'(r);
        #1;
        check(tag, Reg_ROBEN_test, expected);
    endtask

    initial begin
        idle();
        index_test = '0;
        foreach (m_tag[i]) m_tag[i] = 0;
        // First reset edge: state is unknown before it, so no read checks.
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 32; i++) peek("rst_scan", i, 0);
        check("rst_count", Busy_Count, 0);
        check("rst_adone", Alloc_Done, 0);

        // Allocate R10 and read it in the same cycle (old value) and the next.
        idle();
        VALID_Inst = 1'b1; Decoded_WriteEn = 1'b1; Decoded_Rd = 5'd10; Decoded_ROBEN = 5'd1;
        Decoded_Rs = 5'd10;
        #1;
        check("same_cyc_rd", RP_ROBEN1, 0);
        tick();
        idle();
        Decoded_Rs = 5'd10;
        #1;
        check("alloc_rd", RP_ROBEN1, 1);
        check("alloc_busy", RP_Busy1, 1);
        check("alloc_cnt", Busy_Count, 1);
        check("alloc_done", Alloc_Done, 1);

        // WAW rename, stale commit, matching commit.
        do_reset();
        alloc_op(15, 2);
        alloc_op(15, 3);
        peek("waw_tag", 15, 3);
        check("waw_cnt", Busy_Count, 1);
        commit_op(15, 2);
        peek("stale_commit", 15, 3);
        commit_op(15, 3);
        peek("commit_clr", 15, 0);
        check("commit_cnt", Busy_Count, 0);

        // Same-cycle alloc and commit on one register.
        do_reset();
        alloc_op(20, 5);
        idle();
        VALID_Inst = 1'b1; Decoded_WriteEn = 1'b1; Decoded_Rd = 5'd20; Decoded_ROBEN = 5'd7;
        Commit_Valid = 1'b1; Commit_Rd = 5'd20; Commit_ROBEN = 5'd5;
        tick();
        peek("alloc_wins", 20, 7);
        check("alloc_wins_cnt", Busy_Count, 1);

        // Flush with a pending allocation.
        do_reset();
        alloc_op(10, 1);
        alloc_op(11, 2);
        alloc_op(12, 4);
        check("pre_flush_cnt", Busy_Count, 3);
        idle();
        FLUSH_Flag = 1'b1; VALID_Inst = 1'b1; Decoded_WriteEn = 1'b1;
        Decoded_Rd = 5'd13; Decoded_ROBEN = 5'd5;
        tick();
        for (int i = 10; i < 14; i++) peek("flush_tag", i, 0);
        check("flush_cnt", Busy_Count, 0);
        check("flush_adone", Alloc_Done, 0);

        // Guards: R0, ROB full, non-writing instruction, reset over alloc.
        alloc_op(0, 6);
        peek("r0_tag", 0, 0);
        check("r0_adone", Alloc_Done, 0);
        alloc_op(9, 3);
        idle();
        VALID_Inst = 1'b1; Decoded_WriteEn = 1'b1; FULL_FLAG = 1'b1;
        Decoded_Rd = 5'd9; Decoded_ROBEN = 5'd6; Decoded_Rs = 5'd9;
        tick();
        peek("full_tag", 9, 3);
        idle();
        VALID_Inst = 1'b1; Decoded_Rd = 5'd9; Decoded_ROBEN = 5'd8;
        tick();
        peek("sw_tag", 9, 3);
        idle();
        rst = 1'b0; VALID_Inst = 1'b1; Decoded_WriteEn = 1'b1;
        Decoded_Rd = 5'd5; Decoded_ROBEN = 5'd2;
        tick();
        rst = 1'b1;
        peek("rst_alloc5", 5, 0);
        peek("rst_alloc9", 9, 0);
        check("rst_alloc_cnt", Busy_Count, 0);

        // Random traffic.
        for (int n = 0; n < 2000; n++) begin
            int r;
            idle();
            rst             = ($urandom_range(0, 199) != 0);
            FLUSH_Flag      = ($urandom_range(0, 39) == 0);
            VALID_Inst      = ($urandom_range(0, 3) != 0);
            FULL_FLAG       = ($urandom_range(0, 5) == 0);
            Decoded_WriteEn = ($urandom_range(0, 4) != 0);
            Decoded_Rd      = 5'($urandom_range(0, 31));
            Decoded_ROBEN   = 5'($urandom_range(1, 16));
            Decoded_Rs      = 5'($urandom_range(0, 31));
            Decoded_Rt      = 5'($urandom_range(0, 31));
            index_test      = 5'($urandom_range(0, 31));
            Commit_Valid    = $urandom_range(0, 1);
            r = (Commit_Valid && $urandom_range(0, 1)) ? int'(Decoded_Rd) : $urandom_range(0, 31);
            Commit_Rd       = 5'(r);
            Commit_ROBEN    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 16)) : 5'(m_tag[r]);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
